// File: rtl/wb_scratch_mem.sv
// Wishbone-classic word scratchpad with byte lanes, configurable wait states and a transaction counter.
// Define SCRATCH_INIT_CLEAR_EN to zero-fill the array after reset via the CLEAR sequencer.
module wb_scratch_mem #(
    parameter int unsigned ADDR_BITS   = 4,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [31:0] txn_count,
    output logic        busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_BITS;
    localparam int unsigned CW    = 4;
    localparam logic [CW-1:0] WS_INIT = CW'(WAIT_STATES);

`ifdef SCRATCH_INIT_CLEAR_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_ACK = 2'd2, S_CLEAR = 2'd3} state_t;
    localparam state_t RST_STATE = S_CLEAR;
    localparam logic   RST_BUSY  = 1'b1;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_ACK = 2'd2} state_t;
    localparam state_t RST_STATE = S_IDLE;
    localparam logic   RST_BUSY  = 1'b0;
`endif

    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic [ADDR_BITS-1:0]   r_idx;
    logic                   r_we;
    logic [3:0]             r_sel;
    logic [31:0]            r_wdat;
    logic                   r_ack;
    logic [31:0]            r_dat;
    logic [31:0]            r_txn;
    logic                   r_busy;
    logic [31:0]            r_mem [DEPTH];
`ifdef SCRATCH_INIT_CLEAR_EN
    logic [ADDR_BITS-1:0]   r_clr_idx;
`endif

    logic                   w_hit;
    logic                   w_req;
    logic                   w_bus_live;
    logic [ADDR_BITS-1:0]   w_idx;
    logic                   w_unused_adr;

    // Only the bits above the word index take part in the base-address decode.
    assign w_hit        = wbs_adr_i[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2];
    assign w_bus_live   = wbs_cyc_i & wbs_stb_i;
    assign w_req        = w_bus_live & w_hit;
    assign w_idx        = wbs_adr_i[ADDR_BITS+1:2];
    assign w_unused_adr = ^wbs_adr_i[1:0];

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign txn_count = r_txn;
    assign busy      = r_busy;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= RST_STATE;
            r_busy  <= RST_BUSY;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_we    <= 1'b0;
            r_sel   <= '0;
            r_wdat  <= '0;
            r_ack   <= 1'b0;
            r_dat   <= '0;
            r_txn   <= '0;
`ifdef SCRATCH_INIT_CLEAR_EN
            r_clr_idx <= '0;
`endif
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_idx  <= w_idx;
                        r_we   <= wbs_we_i;
                        r_sel  <= wbs_sel_i;
                        r_wdat <= wbs_dat_i;
                        r_busy <= 1'b1;
                        if (WAIT_STATES == 0) begin
                            r_state <= S_ACK;
                            r_ack   <= 1'b1;
                            if (!wbs_we_i) r_dat <= r_mem[w_idx];
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= WS_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    // A master that drops the cycle abandons the access entirely.
                    if (!w_bus_live) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else if (r_cnt == CW'(1)) begin
                        r_state <= S_ACK;
                        r_ack   <= 1'b1;
                        r_cnt   <= '0;
                        if (!r_we) r_dat <= r_mem[r_idx];
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_txn   <= r_txn + 32'd1;
                end
`ifdef SCRATCH_INIT_CLEAR_EN
                S_CLEAR: begin
                    r_clr_idx <= r_clr_idx + ADDR_BITS'(1);
                    if (r_clr_idx == ADDR_BITS'(DEPTH - 1)) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Array storage: writes commit on the edge leaving ACK; contents survive reset.
    always_ff @(posedge wb_clk_i) begin
        if (r_state == S_ACK && r_we) begin
            for (int b = 0; b < 4; b++) begin
                if (r_sel[b]) r_mem[r_idx][8*b +: 8] <= r_wdat[8*b +: 8];
            end
        end
`ifdef SCRATCH_INIT_CLEAR_EN
        if (r_state == S_CLEAR) r_mem[r_clr_idx] <= 32'h0;
`endif
    end

endmodule

// File: doc/wb_scratch_mem.md
# wb_scratch_mem

Parametrised Wishbone-classic scratchpad memory for the user project area, replacing the fixed 16-entry, strobe-indexed store with a properly address-decoded, byte-lane-writable, wait-state-configurable word RAM. It sits directly on the WB MI A slave port and exports a transaction counter and busy flag for the LA/GPIO path. With the clear option compiled in, an internal sequencer zero-fills the array after reset.

## Interface
Parameters:
- ADDR_BITS, 4: word-address width; DEPTH = 2^ADDR_BITS 32-bit words.
- WAIT_STATES, 0: extra cycles inserted between request acceptance and ack (0..15).
- BASE_ADDR, 32'h3000_0000: decode base; bits [31:ADDR_BITS+2] are compared.

Ports:
- wb_clk_i  in  1  sole clock, all state on rising edge.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- wbs_cyc_i  in  1  bus cycle.
- wbs_stb_i  in  1  strobe.
- wbs_we_i  in  1  1 = write.
- wbs_sel_i  in  4  byte-lane enables; bit n covers data [8n+7:8n].
- wbs_adr_i  in  32  byte address; word index = [ADDR_BITS+1:2].
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  one-cycle acknowledge.
- wbs_dat_o  out  32  registered read data.
- txn_count  out  32  number of acked transactions.
- busy  out  1  high in any state other than IDLE.

## Operation
- Valid request: wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]). Non-matching requests are ignored and never acked.
- FSM states: CLEAR (with macro only), IDLE, WAIT, ACK.
- IDLE: on a valid request, latch word index, we, sel and data; go to WAIT with wait counter = WAIT_STATES, or go straight to ACK if WAIT_STATES = 0.
- WAIT: decrement the counter; enter ACK when it reaches 1. If wbs_cyc_i or wbs_stb_i drops, abort to IDLE: no ack, no write, no count.
- ACK: wbs_ack_o = 1 for exactly one cycle, then IDLE.
  - A write commits at the edge ending ACK, for selected byte lanes only; unselected bytes are unchanged. Write acks leave wbs_dat_o unchanged.
  - For a read, wbs_dat_o is loaded with mem[index] on the edge entering ACK. wbs_sel_i is ignored for reads; the full word is returned.
  - txn_count increments on the edge ending ACK and wraps 32'hFFFF_FFFF -> 0.
- Back-to-back: a held request is accepted again in the IDLE cycle following ACK, giving one access per WAIT_STATES+2 cycles.
- A read immediately after a write to the same word returns the new data, because the write commits before the next IDLE.

## Timing
- Reset values: wbs_ack_o = 0, wbs_dat_o = 0, txn_count = 0, wait counter = 0. State is IDLE (busy = 0), or CLEAR (busy = 1) with the macro.
- Ack latency: ack is high in cycle WAIT_STATES+1, counting the request-sampling cycle as 0.
- Reset asserted mid-transaction: outputs drop to reset values asynchronously. The pending write is discarded, and no ack is issued after release.
- Memory contents are not reset, except through the clear sequencer.

## Configuration
- SCRATCH_INIT_CLEAR_EN defined:
  - After reset release, CLEAR writes 32'h0 to words 0..DEPTH-1, one per cycle, for DEPTH cycles, then enters IDLE.
  - busy = 1 throughout CLEAR. Requests are not accepted; a held request is accepted in the first IDLE cycle.
  - Reset asserted during CLEAR restarts the sequence at word 0.
- SCRATCH_INIT_CLEAR_EN undefined: there is no CLEAR state, reset goes directly to IDLE, and contents are X in simulation until written.

## Test plan
- Write 32'hDEADBEEF to BASE+0x8 with sel 4'hF, then read BASE+0x8 -> ack 1 cycle after request (WAIT_STATES = 0), read data 32'hDEADBEEF, txn_count = 2.
- Byte lanes: write 32'h11223344 (sel F), then write 32'hAABBCCDD with sel 4'b0101, then read -> 32'h11BB33DD.
- WAIT_STATES = 3: ack is high exactly in cycle 4. Drop stb in cycle 2 -> no ack, memory unchanged, txn_count unchanged.
- Request at BASE + 0x1000 (ADDR_BITS = 4) -> no ack for 20 cycles, busy stays 0. Preload txn_count by running 2^32-1 acks, or by force in sim, then one more ack -> txn_count = 0.
- Assert reset during WAIT of a write -> ack never rises, and a read of the target word after reset returns its old value.
- With SCRATCH_INIT_CLEAR_EN: release reset with a read held on bus -> busy for 16 cycles, ack in cycle 17, data 0. Reset at clear cycle 8 -> clear restarts and busy lasts a full 16 cycles.
